rgb_pwm_ctrl: RTL and testbench



---
 rtl/rgb_pwm_pkg.sv | 39 +++
 rtl/rgb_pwm_if.sv | 10 +
 rtl/rgb_pwm_chan.sv | 45 ++++
 rtl/rgb_pwm_ctrl.sv | 151 +++++++++++++++
 tb/tb_rgb_pwm_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB LED PWM/blink/breathe controller.
package rgb_pwm_pkg;

  localparam logic [3:0] ADDR_CR0      = 4'd0;
  localparam logic [3:0] ADDR_PRESC_LO = 4'd1;
  localparam logic [3:0] ADDR_PRESC_HI = 4'd2;
  localparam logic [3:0] ADDR_ON_TIME  = 4'd3;
  localparam logic [3:0] ADDR_OFF_TIME = 4'd4;
  localparam logic [3:0] ADDR_DUTY_R   = 4'd5;
  localparam logic [3:0] ADDR_DUTY_G   = 4'd6;
  localparam logic [3:0] ADDR_DUTY_B   = 4'd7;
  localparam logic [3:0] ADDR_BR_STEP  = 4'd8;

  localparam int unsigned CR0_EN  = 7;
  localparam int unsigned CR0_BRE = 6;

  typedef enum logic [1:0] {IDLE, WARM, ON, OFF} state_t;

  typedef struct packed {
    logic       en;
    logic       bre;
    logic [9:0] presc;
    logic [7:0] on_time;
    logic [7:0] off_time;
    logic [7:0] duty_r;
    logic [7:0] duty_g;
    logic [7:0] duty_b;
    logic [7:0] br_step;
  } regs_t;

  // Frame-aligned copies of the timing/fade settings; duties live in each channel.
  typedef struct packed {
    logic       bre;
    logic [7:0] on_time;
    logic [7:0] off_time;
    logic [7:0] br_step;
  } shd_t;

endpackage

// File: rtl/rgb_pwm_if.sv
// Byte-wide write-only register bus between the SoC and the LED controller.
interface rgb_pwm_if;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdat;

  modport master (output cs, we, addr, wdat);
  modport slave  (input  cs, we, addr, wdat);
endinterface

// File: rtl/rgb_pwm_chan.sv
// One LED channel: frame-aligned duty shadow, fade scaling, compare and output register.
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DUTY_W-1:0] duty_nxt,
  input  logic              bre,
  input  state_t            state,
  input  state_t            state_nxt,
  input  logic [7:0]        lvl,
  input  logic [DUTY_W-1:0] cnt,
  output logic              pwm
);

  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] eff;
  logic [DUTY_W+7:0] prod;
  logic              gate;

  always_comb begin
    prod = (DUTY_W+8)'(duty_q) * (DUTY_W+8)'({1'b0, lvl} + 9'd1);
    eff  = '0;
    if (bre)
      eff = DUTY_W'(prod >> 8);
    else if (state == ON)
      eff = duty_q;
    gate = ((state == ON) || (state == OFF)) && (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load)
        duty_q <= duty_nxt;
      pwm <= gate && (cnt < eff);
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Three-channel LED PWM controller: register file, prescaler, frame counter,
// fade level and the IDLE/WARM/ON/OFF sequencing FSM.
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PRESC_W = 10,
  parameter int unsigned DUTY_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  rgb_pwm_if.slave   bus,
  output logic [2:0] rgb_pwm,
  output logic       rgbled_en,
  output logic       on_phase
);

  regs_t               regs_q, regs_d;
  shd_t                shd_q;
  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  pcnt;
  logic [DUTY_W-1:0]   cnt;
  logic [7:0]          fcnt_q, fcnt_d;
  logic [7:0]          lvl;
  logic [8:0]          lvl_up;
  logic                tick, frame_start, run;
  logic [2:0][7:0]     duty_nxt;

  // regs_d doubles as the write-through source for shadows on a frame_start edge.
  always_comb begin
    regs_d = regs_q;
    if (bus.cs && bus.we) begin
      case (bus.addr)
        ADDR_CR0: begin
          regs_d.en  = bus.wdat[CR0_EN];
          regs_d.bre = bus.wdat[CR0_BRE];
        end
        ADDR_PRESC_LO: regs_d.presc[7:0] = bus.wdat;
        ADDR_PRESC_HI: regs_d.presc[9:8] = bus.wdat[1:0];
        ADDR_ON_TIME:  regs_d.on_time    = bus.wdat;
        ADDR_OFF_TIME: regs_d.off_time   = bus.wdat;
        ADDR_DUTY_R:   regs_d.duty_r     = bus.wdat;
        ADDR_DUTY_G:   regs_d.duty_g     = bus.wdat;
        ADDR_DUTY_B:   regs_d.duty_b     = bus.wdat;
        ADDR_BR_STEP:  regs_d.br_step    = bus.wdat;
        default: ;
      endcase
    end
  end

  assign tick        = (state_q != IDLE) && (pcnt >= regs_q.presc);
  assign frame_start = tick && (cnt == '1);
  assign run         = (state_q != IDLE) && (state_d != IDLE);
  assign lvl_up      = {1'b0, lvl} + {1'b0, shd_q.br_step};
  assign duty_nxt    = {regs_d.duty_b, regs_d.duty_g, regs_d.duty_r};

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!regs_q.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WARM;
        WARM: if (frame_start) begin
          if (fcnt_q != '0) begin
            state_d = ON;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
        ON: if (frame_start) begin
          if (shd_q.on_time == '0) begin
            fcnt_d = '0;
          end else if (fcnt_q == shd_q.on_time - 8'd1) begin
            state_d = OFF;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
        OFF: if (frame_start) begin
          if ((shd_q.off_time == '0) || (fcnt_q == shd_q.off_time - 8'd1)) begin
            state_d = ON;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == IDLE)
      fcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= '0;
      shd_q     <= '0;
      state_q   <= IDLE;
      fcnt_q    <= '0;
      pcnt      <= '0;
      cnt       <= '0;
      lvl       <= '0;
      rgbled_en <= 1'b0;
      on_phase  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      rgbled_en <= (state_d != IDLE);
      on_phase  <= (state_d == ON);
      if (frame_start)
        shd_q <= '{bre: regs_d.bre, on_time: regs_d.on_time,
                   off_time: regs_d.off_time, br_step: regs_d.br_step};
      if (!run) begin
        pcnt <= '0;
        cnt  <= '0;
        lvl  <= '0;
      end else begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick)
          cnt <= cnt + 1'b1;
        // Fade steps toward the state being entered, so the first ON frame is already lit.
        if (frame_start) begin
          if (state_d == ON)
            lvl <= lvl_up[8] ? 8'hFF : lvl_up[7:0];
          else if (state_d == OFF)
            lvl <= (lvl < shd_q.br_step) ? 8'h00 : lvl - shd_q.br_step;
        end
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    rgb_pwm_chan #(.DUTY_W(DUTY_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .load      (frame_start),
      .duty_nxt  (duty_nxt[i]),
      .bre       (shd_q.bre),
      .state     (state_q),
      .state_nxt (state_d),
      .lvl       (lvl),
      .cnt       (cnt),
      .pwm       (rgb_pwm[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: warm-up, duty, glitch-free update, blink, fade, disable and reset.
module tb_rgb_pwm_ctrl;
  import rgb_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rgb_pwm;
  logic       rgbled_en;
  logic       on_phase;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int hr, hg, hb, hon;
  int n, pr, pany;
  int fexp [13] = '{64, 128, 192, 255, 255, 255, 255, 255, 191, 127, 63, 0, 64};

  rgb_pwm_if bus ();

  rgb_pwm_ctrl #(.PRESC_W(10), .DUTY_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rgb_pwm   (rgb_pwm),
    .rgbled_en (rgbled_en),
    .on_phase  (on_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdat = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  // Counts highs over one 256-clk window; optionally writes a register mid-window.
  task automatic frame(input bit do_wr, input logic [3:0] a, input logic [7:0] d);
    hr = 0; hg = 0; hb = 0; hon = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hr += int'(rgb_pwm[0]); hg += int'(rgb_pwm[1]);
      hb += int'(rgb_pwm[2]); hon += int'(on_phase);
      if (do_wr && i == 100) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdat = d;
      end
      if (do_wr && i == 101) begin
        bus.cs = 1'b0; bus.we = 1'b0;
      end
    end
  endtask

  task automatic wait_on(input logic lvl_w, input int bound,
                         output int cnt_o, output int r_o, output int any_o);
    cnt_o = 0; r_o = 0; any_o = 0;
    while (cnt_o < bound) begin
      @(negedge clk);
      cnt_o++;
      r_o   += int'(rgb_pwm[0]);
      any_o += int'(rgb_pwm != 3'b000);
      if (on_phase == lvl_w) break;
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdat = '0;
    repeat (3) @(negedge clk);
    chk("reset pwm", int'(rgb_pwm), 0);
    chk("reset en", int'(rgbled_en), 0);
    chk("reset on", int'(on_phase), 0);
    rst = 1'b0;
    @(negedge clk);

    wr(ADDR_PRESC_LO, 8'd0);
    wr(ADDR_DUTY_R, 8'd64);
    wr(ADDR_ON_TIME, 8'd0);
    wr(ADDR_DUTY_G, 8'd0);
    wr(ADDR_DUTY_B, 8'd255);
    wr(ADDR_CR0, 8'h80);
    chk("en same edge", int'(rgbled_en), 0);
    @(negedge clk);
    chk("en next edge", int'(rgbled_en), 1);
    chk("warm pwm", int'(rgb_pwm), 0);
    wait_on(1'b1, 2000, n, pr, pany);
    chk("warm length", n, 512);
    chk("warm quiet", pany, 0);

    frame(1'b0, '0, '0);
    chk("steady R", hr, 64);
    chk("duty0 G", hg, 0);
    chk("duty255 B", hb, 255);
    chk("steady on", hon, 256);

    frame(1'b1, ADDR_DUTY_R, 8'd128);
    chk("midframe old R", hr, 64);
    frame(1'b0, '0, '0);
    chk("next frame R", hr, 128);

    wr(ADDR_OFF_TIME, 8'd3);
    wr(ADDR_ON_TIME, 8'd2);
    wr(ADDR_PRESC_LO, 8'd1);
    wait_on(1'b0, 6000, n, pr, pany);
    chk("blink starts", int'(n < 6000), 1);
    wait_on(1'b1, 4000, n, pr, pany);
    chk("off length", n, 1536);
    chk("off dark", pany, 0);
    wait_on(1'b0, 4000, n, pr, pany);
    chk("on length", n, 1024);
    chk("on R highs", pr, 512);

    wait_on(1'b1, 4000, n, pr, pany);
    repeat (50) @(negedge clk);
    wr(ADDR_CR0, 8'h00);
    @(negedge clk);
    chk("dis pwm", int'(rgb_pwm), 0);
    chk("dis en", int'(rgbled_en), 0);
    chk("dis on", int'(on_phase), 0);

    wr(ADDR_PRESC_LO, 8'd0);
    wr(ADDR_DUTY_R, 8'd255);
    wr(ADDR_BR_STEP, 8'd64);
    wr(ADDR_ON_TIME, 8'd8);
    wr(ADDR_OFF_TIME, 8'd4);
    wr(ADDR_CR0, 8'hC0);
    @(negedge clk);
    wait_on(1'b1, 2000, n, pr, pany);
    chk("rewarm length", n, 512);
    for (int k = 0; k < 13; k++) begin
      frame(1'b0, '0, '0);
      chk($sformatf("fade frame %0d", k), hr, fexp[k]);
    end

    repeat (77) @(negedge clk);
    rst = 1'b1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = ADDR_DUTY_G; bus.wdat = 8'hFF;
    @(negedge clk);
    chk("rst pwm", int'(rgb_pwm), 0);
    chk("rst en", int'(rgbled_en), 0);
    chk("rst on", int'(on_phase), 0);
    rst = 1'b0; bus.cs = 1'b0; bus.we = 1'b0;
    repeat (20) @(negedge clk);
    chk("post-rst idle", int'(rgbled_en), 0);

    wr(ADDR_DUTY_R, 8'd64);
    wr(ADDR_CR0, 8'h80);
    @(negedge clk);
    chk("post-rst en", int'(rgbled_en), 1);
    wait_on(1'b1, 2000, n, pr, pany);
    chk("post-rst warm", n, 512);
    frame(1'b0, '0, '0);
    chk("post-rst R", hr, 64);
    chk("post-rst G", hg, 0);
    chk("post-rst B", hb, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
